muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 36 +++
 rtl/muldiv_ctrl_step.sv | 39 +++
 rtl/muldiv_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit:
// operation and FSM encodings, iteration count and operand helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } state_e;

  localparam int unsigned CALC_CYCLES = 32;
  localparam int unsigned CNT_W       = $clog2(CALC_CYCLES);

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Magnitude of a 32-bit operand; 0x80000000 maps onto itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add multiply on {acc,q}, or restoring
// divide with acc as partial remainder and q as dividend/quotient.
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  logic        i_is_div,
  input  logic [31:0] i_acc,
  input  logic [31:0] i_q,
  input  logic [31:0] i_b,
  output logic [31:0] o_acc,
  output logic [31:0] o_q
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [31:0] w_rem;
  logic        w_ge;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : 33'd0);
    w_shift = {i_acc, i_q[31]};
    w_ge    = (w_shift >= {1'b0, i_b});
    // When w_shift >= b the true difference is below b, so 32 bits suffice.
    w_rem   = w_shift[31:0] - i_b;
    if (i_is_div) begin
      if (w_ge) begin
        o_acc = w_rem;
        o_q   = {i_q[30:0], 1'b1};
      end else begin
        o_acc = w_shift[31:0];
        o_q   = {i_q[30:0], 1'b0};
      end
    end else begin
      o_acc = w_sum[32:1];
      o_q   = {w_sum[0], i_q[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: IDLE -> PREP -> CALC(x32) -> FIX,
// with a direct IDLE -> FIX path for division by zero.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_wr,
  input  logic        lo_wr,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  logic [31:0]      r_acc;
  logic [31:0]      r_q;
  logic [31:0]      r_b;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_hold;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_is_div;
  logic             w_signed;
  logic [31:0]      w_mag_rs;
  logic [31:0]      w_mag_rt;
  logic [31:0]      w_acc_nx;
  logic [31:0]      w_q_nx;
  logic [63:0]      w_prod_neg;
  logic [31:0]      w_hi_fix;
  logic [31:0]      w_lo_fix;

  muldiv_step u_step (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_acc_nx),
    .o_q      (w_q_nx)
  );

  always_comb begin
    w_is_div   = op_is_div(r_op);
    w_signed   = op_is_signed(r_op);
    w_mag_rs   = mag32(r_rs, w_signed);
    w_mag_rt   = mag32(r_rt, w_signed);
    w_prod_neg = 64'd0 - {r_acc, r_q};
    w_hi_fix   = r_acc;
    w_lo_fix   = r_q;
    if (w_is_div) begin
      if (r_neg_r) w_hi_fix = 32'd0 - r_acc;
      if (r_neg_q) w_lo_fix = 32'd0 - r_q;
    end else if (r_neg_q) begin
      w_hi_fix = w_prod_neg[63:32];
      w_lo_fix = w_prod_neg[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MULT;
      r_rs      <= '0;
      r_rt      <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_hold <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy && hi_wr) r_hi <= rs_data;
      if (!r_busy && lo_wr) r_lo <= rs_data;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op_e'(op);
            r_rs   <= rs_data;
            r_rt   <= rt_data;
            r_busy <= 1'b1;
            if (op[1] && (rt_data == '0)) begin
              // Divide by zero: preload the fixed result; FIX holds one
              // extra cycle so completion lands two edges after start.
              r_acc     <= rs_data;
              r_q       <= '1;
              r_neg_q   <= 1'b0;
              r_neg_r   <= 1'b0;
              r_dz_hold <= 1'b1;
              r_state   <= S_FIX;
            end else begin
              r_state <= S_PREP;
            end
          end
        end
        S_PREP: begin
          r_acc   <= '0;
          r_q     <= w_mag_rs;
          r_b     <= w_mag_rt;
          r_neg_q <= w_signed & (r_rs[31] ^ r_rt[31]);
          r_neg_r <= w_signed & w_is_div & r_rs[31];
          r_cnt   <= CNT_W'(CALC_CYCLES - 1);
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (r_dz_hold) begin
            r_dz_hold <= 1'b0;
          end else begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
